// File: rtl/fsb_pad_deserializer_if.sv
// Pad-side and node-side signals of the FSB pad deserializer.
// Defining FSB_DESER_PARITY_EN adds the pad_par_i beat parity bit.
`timescale 1ns/1ps

interface fsb_pad_deserializer_if #(
    parameter int PAD_WIDTH = 8,
    parameter int PKT_WIDTH = 80
) ();
    logic                 pad_v_i;
    logic                 pad_sof_i;
    logic [PAD_WIDTH-1:0] pad_data_i;
`ifdef FSB_DESER_PARITY_EN
    logic                 pad_par_i;
`endif
    logic                 pad_ready_o;
    logic                 node_v_o;
    logic [PKT_WIDTH-1:0] node_data_o;
    logic                 node_ready_i;
    logic                 err_o;
    logic [7:0]           err_cnt_o;

    // master drives beats and consumes packets; slave is the deserializer.
    modport master (
        output pad_v_i, pad_sof_i, pad_data_i,
`ifdef FSB_DESER_PARITY_EN
        output pad_par_i,
`endif
        output node_ready_i,
        input  pad_ready_o, node_v_o, node_data_o, err_o, err_cnt_o
    );

    modport slave (
        input  pad_v_i, pad_sof_i, pad_data_i,
`ifdef FSB_DESER_PARITY_EN
        input  pad_par_i,
`endif
        input  node_ready_i,
        output pad_ready_o, node_v_o, node_data_o, err_o, err_cnt_o
    );
endinterface

// File: rtl/fsb_pad_deserializer.sv
// Assembles PAD_WIDTH-bit pad beats (first beat = LSBs) into PKT_WIDTH-bit FSB packets
// behind a one-packet output register. FSB_DESER_PARITY_EN enables per-beat odd parity.
`timescale 1ns/1ps

module fsb_pad_deserializer #(
    parameter int PAD_WIDTH = 8,
    parameter int PKT_WIDTH = 80
) (
    input logic                   clk_i,
    input logic                   reset_i,
    fsb_pad_deserializer_if.slave bus
);
    localparam int BEATS = PKT_WIDTH / PAD_WIDTH;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ASSM = 2'd1,
        HOLD = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
    logic [PKT_WIDTH-1:0] asm_q, asm_d;
    logic [PKT_WIDTH-1:0] out_data_q, out_data_d;
    logic                 out_v_q, out_v_d;
    logic                 err_q, err_d;
    logic [7:0]           err_cnt_q, err_cnt_d;
    logic                 live_q;

    logic accept;
    logic drain;
    logic drop;
    logic beat_bad;
    logic pkt_bad;
    logic pad_ready;

    // live_q keeps pad_ready_o low for the first cycle after reset release.
    assign pad_ready = live_q & (state_q != HOLD);
    assign accept    = bus.pad_v_i & pad_ready;
    assign drain     = out_v_q & bus.node_ready_i;

`ifdef FSB_DESER_PARITY_EN
    logic bad_q, bad_d;

    // Data plus parity bit must carry an odd number of ones.
    assign beat_bad = ~(^{bus.pad_data_i, bus.pad_par_i});
    assign pkt_bad  = bad_q | beat_bad;
`else
    assign beat_bad = 1'b0;
    assign pkt_bad  = 1'b0;
`endif

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        asm_d      = asm_q;
        out_v_d    = out_v_q;
        out_data_d = out_data_q;
        err_d      = 1'b0;
        err_cnt_d  = err_cnt_q;
        drop       = 1'b0;
`ifdef FSB_DESER_PARITY_EN
        bad_d      = bad_q;
`endif

        if (drain) begin
            out_v_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bus.pad_sof_i) begin
                        asm_d      = {{(PKT_WIDTH-PAD_WIDTH){1'b0}}, bus.pad_data_i};
                        beat_cnt_d = CNT_W'(1);
                        state_d    = ASSM;
`ifdef FSB_DESER_PARITY_EN
                        bad_d      = beat_bad;
`endif
                    end else begin
                        drop = 1'b1;
                    end
                end
            end

            ASSM: begin
                if (accept) begin
                    if (bus.pad_sof_i) begin
                        // A new sof abandons the partial packet and restarts on this beat.
                        drop       = 1'b1;
                        asm_d      = {{(PKT_WIDTH-PAD_WIDTH){1'b0}}, bus.pad_data_i};
                        beat_cnt_d = CNT_W'(1);
`ifdef FSB_DESER_PARITY_EN
                        bad_d      = beat_bad;
`endif
                    end else begin
                        for (int k = 0; k < BEATS; k++) begin
                            if (beat_cnt_q == CNT_W'(k)) begin
                                asm_d[k*PAD_WIDTH +: PAD_WIDTH] = bus.pad_data_i;
                            end
                        end
                        beat_cnt_d = beat_cnt_q + 1'b1;
`ifdef FSB_DESER_PARITY_EN
                        bad_d      = pkt_bad;
`endif
                        if (beat_cnt_q == LAST_BEAT) begin
                            beat_cnt_d = '0;
                            if (pkt_bad) begin
                                drop    = 1'b1;
                                state_d = IDLE;
`ifdef FSB_DESER_PARITY_EN
                                bad_d   = 1'b0;
`endif
                            end else if (!out_v_q || drain) begin
                                out_v_d    = 1'b1;
                                out_data_d = asm_d;
                                state_d    = IDLE;
                            end else begin
                                state_d = HOLD;
                            end
                        end
                    end
                end
            end

            HOLD: begin
                if (drain) begin
                    out_v_d    = 1'b1;
                    out_data_d = asm_q;
                    state_d    = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (drop) begin
            err_d = 1'b1;
            if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            out_v_q    <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= 8'd0;
            live_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            out_v_q    <= out_v_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
            live_q     <= 1'b1;
        end
    end

    // NOTE: the wide data registers are reset as well, so node_data_o reads zero after any reset.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            asm_q      <= '0;
            out_data_q <= '0;
        end else begin
            asm_q      <= asm_d;
            out_data_q <= out_data_d;
        end
    end

`ifdef FSB_DESER_PARITY_EN
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            bad_q <= 1'b0;
        end else begin
            bad_q <= bad_d;
        end
    end
`endif

    assign bus.pad_ready_o = pad_ready;
    assign bus.node_v_o    = out_v_q;
    assign bus.node_data_o = out_data_q;
    assign bus.err_o       = err_q;
    assign bus.err_cnt_o   = err_cnt_q;

endmodule
